// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Also tracks pending destination registers for RAW/WAW hazard checks.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 16,
    parameter int REG_W      = 4,
    parameter int FIXED_PRIO = 0,
    localparam int NUM_REGS  = 2**REG_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                a_valid,
    input  logic [REG_W-1:0]    a_reg,
    input  logic [DATA_W-1:0]   a_data,
    output logic                a_ready,
    input  logic                m_valid,
    input  logic [REG_W-1:0]    m_reg,
    input  logic [DATA_W-1:0]   m_data,
    output logic                m_ready,
    input  logic                alloc_valid,
    input  logic [REG_W-1:0]    alloc_reg,
    output logic                alloc_ready,
    input  logic [REG_W-1:0]    src1_reg,
    input  logic [REG_W-1:0]    src2_reg,
    output logic                src1_busy,
    output logic                src2_busy,
    output logic                wr_en,
    output logic [REG_W-1:0]    wr_reg,
    output logic [DATA_W-1:0]   wr_data,
    output logic [NUM_REGS-1:0] busy_vec
);

    // rr_ptr: 0 means A wins the next contested cycle, 1 means M does
    logic                rr_ptr;
    logic                a_gnt;
    logic                m_gnt;
    logic                acc;
    logic                acc_wr;
    logic [REG_W-1:0]    acc_reg;
    logic [DATA_W-1:0]   acc_data;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        a_gnt = 1'b0;
        m_gnt = 1'b0;
        if (!rst) begin
            if (a_valid && (!m_valid || FIXED_PRIO != 0 || !rr_ptr))
                a_gnt = 1'b1;
            else if (m_valid)
                m_gnt = 1'b1;
        end
    end

    assign a_ready  = a_gnt;
    assign m_ready  = m_gnt;
    assign acc      = a_gnt || m_gnt;
    assign acc_reg  = a_gnt ? a_reg : m_reg;
    assign acc_data = a_gnt ? a_data : m_data;
    assign acc_wr   = acc && (acc_reg != '0);

    assign alloc_ready = !busy_q[alloc_reg] || (alloc_reg == '0)
                       || (acc && acc_reg == alloc_reg);

    // Clear first so a same-cycle reservation of the register wins
    always_comb begin
        busy_d = busy_q;
        if (acc)
            busy_d[acc_reg] = 1'b0;
        if (alloc_valid && alloc_ready)
            busy_d[alloc_reg] = 1'b1;
        busy_d[0] = 1'b0;
    end

    assign src1_busy = busy_q[src1_reg] && (src1_reg != '0);
    assign src2_busy = busy_q[src2_reg] && (src2_reg != '0);
    assign busy_vec  = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
            busy_q  <= '0;
            rr_ptr  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            wr_en  <= acc_wr;
            if (acc_wr) begin
                wr_reg  <= acc_reg;
                wr_data <= acc_data;
            end
            if (a_valid && m_valid)
                rr_ptr <= a_gnt;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter (round-robin and fixed-priority).
// Expected writes are queued at the accepting edge and retired on wr_en.
module tb_regfile_wb_arbiter;

    typedef struct packed {
        logic [3:0]  r;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_valid = 1'b0;
    logic [3:0]  a_reg = '0;
    logic [15:0] a_data = '0;
    logic        m_valid = 1'b0;
    logic [3:0]  m_reg = '0;
    logic [15:0] m_data = '0;
    logic        alloc_valid = 1'b0;
    logic [3:0]  alloc_reg = '0;
    logic [3:0]  src1_reg = '0;
    logic [3:0]  src2_reg = '0;

    logic        a_ready, m_ready, alloc_ready, src1_busy, src2_busy;
    logic        wr_en;
    logic [3:0]  wr_reg;
    logic [15:0] wr_data;
    logic [15:0] busy_vec;

    logic        fp_a_ready, fp_m_ready, fp_alloc_ready;
    logic        fp_src1_busy, fp_src2_busy, fp_wr_en;
    logic [3:0]  fp_wr_reg;
    logic [15:0] fp_wr_data;
    logic [15:0] fp_busy_vec;

    int n_checks = 0;
    int n_fail   = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(16), .REG_W(4), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data), .m_ready(m_ready),
        .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
        .alloc_ready(alloc_ready),
        .src1_reg(src1_reg), .src2_reg(src2_reg),
        .src1_busy(src1_busy), .src2_busy(src2_busy),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
        .busy_vec(busy_vec)
    );

    regfile_wb_arbiter #(.DATA_W(16), .REG_W(4), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
        .a_ready(fp_a_ready),
        .m_valid(m_valid), .m_reg(m_reg), .m_data(m_data),
        .m_ready(fp_m_ready),
        .alloc_valid(alloc_valid), .alloc_reg(alloc_reg),
        .alloc_ready(fp_alloc_ready),
        .src1_reg(src1_reg), .src2_reg(src2_reg),
        .src1_busy(fp_src1_busy), .src2_busy(fp_src2_busy),
        .wr_en(fp_wr_en), .wr_reg(fp_wr_reg), .wr_data(fp_wr_data),
        .busy_vec(fp_busy_vec)
    );

    task automatic set_a(input logic v, input logic [3:0] r,
                         input logic [15:0] d);
        a_valid = v; a_reg = r; a_data = d;
    endtask

    task automatic set_m(input logic v, input logic [3:0] r,
                         input logic [15:0] d);
        m_valid = v; m_reg = r; m_data = d;
    endtask

    // Advance one edge; if the bench expects a write accepted, queue it
    task automatic edge_push(input logic acc, input logic [3:0] r,
                             input logic [15:0] d);
        wr_t e;
        @(posedge clk);
        if (acc && r != 4'd0) begin
            e.r = r;
            e.d = d;
            exp_q.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset;
        set_a(1'b1, 4'd3, 16'h1111);
        set_m(1'b1, 4'd4, 16'h2222);
        #2;
        n_checks++;
        if (wr_en !== 1'b0 || wr_reg !== 4'd0 || wr_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_wr: en=%b reg=%0d data=%h, expected 0 0 0000",
                     wr_en, wr_reg, wr_data);
        end
        n_checks++;
        if (busy_vec !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_busy: got %h, expected 0000", busy_vec);
        end
        n_checks++;
        if (a_ready !== 1'b0 || m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: a=%b m=%b, expected 0 0",
                     a_ready, m_ready);
        end
        set_a(1'b0, 4'd0, 16'h0);
        set_m(1'b0, 4'd0, 16'h0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_a_only;
        set_a(1'b1, 4'd3, 16'h1234);
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL a_only_ready: a=%b m=%b, expected 1 0",
                     a_ready, m_ready);
        end
        edge_push(1'b1, 4'd3, 16'h1234);
        set_a(1'b0, 4'd0, 16'h0);
        edge_push(1'b0, 4'd0, 16'h0);
        edge_push(1'b0, 4'd0, 16'h0);
    endtask

    task automatic test_round_robin;
        set_a(1'b1, 4'd2, 16'hAAAA);
        set_m(1'b1, 4'd5, 16'h5555);
        for (int rep = 0; rep < 2; rep++) begin
            #1;
            n_checks++;
            if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_first: rep %0d a=%b m=%b, expected 1 0",
                         rep, a_ready, m_ready);
            end
            edge_push(1'b1, 4'd2, 16'hAAAA);
            n_checks++;
            if (a_ready !== 1'b0 || m_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_second: rep %0d a=%b m=%b, expected 0 1",
                         rep, a_ready, m_ready);
            end
            edge_push(1'b1, 4'd5, 16'h5555);
        end
        set_a(1'b0, 4'd0, 16'h0);
        set_m(1'b0, 4'd0, 16'h0);
        edge_push(1'b0, 4'd0, 16'h0);
        edge_push(1'b0, 4'd0, 16'h0);
    endtask

    task automatic test_scoreboard;
        alloc_valid = 1'b1;
        alloc_reg = 4'd7;
        src1_reg = 4'd7;
        #1;
        n_checks++;
        if (alloc_ready !== 1'b1 || src1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_alloc_free: ready=%b busy=%b, expected 1 0",
                     alloc_ready, src1_busy);
        end
        edge_push(1'b0, 4'd0, 16'h0);
        n_checks++;
        if (busy_vec !== 16'h0080 || src1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set: vec=%h src1=%b, expected 0080 1",
                     busy_vec, src1_busy);
        end
        n_checks++;
        if (alloc_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_waw: alloc_ready=%b, expected 0", alloc_ready);
        end
        alloc_valid = 1'b0;
        set_m(1'b1, 4'd7, 16'hBEEF);
        #1;
        n_checks++;
        if (m_ready !== 1'b1 || alloc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_clear_ready: m=%b alloc=%b, expected 1 1",
                     m_ready, alloc_ready);
        end
        edge_push(1'b1, 4'd7, 16'hBEEF);
        set_m(1'b0, 4'd0, 16'h0);
        #1;
        n_checks++;
        if (busy_vec !== 16'h0 || src1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_clear: vec=%h src1=%b, expected 0000 0",
                     busy_vec, src1_busy);
        end
        alloc_valid = 1'b1;
        edge_push(1'b0, 4'd0, 16'h0);
        set_m(1'b1, 4'd7, 16'h0077);
        #1;
        n_checks++;
        if (alloc_ready !== 1'b1 || busy_vec !== 16'h0080) begin
            n_fail++;
            $display("FAIL sb_same_cycle_ready: ready=%b vec=%h, expected 1 0080",
                     alloc_ready, busy_vec);
        end
        edge_push(1'b1, 4'd7, 16'h0077);
        alloc_valid = 1'b0;
        set_m(1'b0, 4'd0, 16'h0);
        #1;
        n_checks++;
        if (busy_vec !== 16'h0080) begin
            n_fail++;
            $display("FAIL sb_set_wins: vec=%h, expected 0080", busy_vec);
        end
        set_m(1'b1, 4'd7, 16'h7777);
        edge_push(1'b1, 4'd7, 16'h7777);
        set_m(1'b0, 4'd0, 16'h0);
        edge_push(1'b0, 4'd0, 16'h0);
        src1_reg = 4'd0;
    endtask

    task automatic test_r0;
        set_a(1'b1, 4'd0, 16'hFFFF);
        #1;
        n_checks++;
        if (a_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL r0_ready: a_ready=%b, expected 1", a_ready);
        end
        edge_push(1'b1, 4'd0, 16'hFFFF);
        set_a(1'b0, 4'd0, 16'h0);
        n_checks++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_wr_en: wr_en=%b, expected 0", wr_en);
        end
        alloc_valid = 1'b1;
        alloc_reg = 4'd0;
        src2_reg = 4'd0;
        #1;
        n_checks++;
        if (alloc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL r0_alloc_ready: ready=%b, expected 1", alloc_ready);
        end
        edge_push(1'b0, 4'd0, 16'h0);
        alloc_valid = 1'b0;
        n_checks++;
        if (busy_vec !== 16'h0 || src2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_busy: vec=%h src2=%b, expected 0000 0",
                     busy_vec, src2_busy);
        end
    endtask

    task automatic test_async_reset;
        alloc_valid = 1'b1;
        alloc_reg = 4'd4;
        set_a(1'b1, 4'd8, 16'h0808);
        set_m(1'b1, 4'd9, 16'h0909);
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_pre_contest: a=%b m=%b, expected 1 0",
                     a_ready, m_ready);
        end
        edge_push(1'b1, 4'd8, 16'h0808);
        set_a(1'b0, 4'd0, 16'h0);
        set_m(1'b0, 4'd0, 16'h0);
        alloc_reg = 4'd5;
        edge_push(1'b0, 4'd0, 16'h0);
        alloc_reg = 4'd6;
        edge_push(1'b0, 4'd0, 16'h0);
        alloc_reg = 4'd7;
        set_a(1'b1, 4'd1, 16'h1111);
        edge_push(1'b1, 4'd1, 16'h1111);
        alloc_valid = 1'b0;
        set_a(1'b0, 4'd0, 16'h0);
        n_checks++;
        if (wr_en !== 1'b1 || busy_vec !== 16'h00F0) begin
            n_fail++;
            $display("FAIL ar_setup: wr_en=%b vec=%h, expected 1 00F0",
                     wr_en, busy_vec);
        end
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || busy_vec !== 16'h0 || wr_data !== 16'h0) begin
            n_fail++;
            $display("FAIL ar_immediate: wr_en=%b vec=%h data=%h, expected 0 0000 0000",
                     wr_en, busy_vec, wr_data);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        set_a(1'b1, 4'd2, 16'h2222);
        set_m(1'b1, 4'd3, 16'h3333);
        #1;
        n_checks++;
        if (a_ready !== 1'b1 || m_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_ptr_reset: a=%b m=%b, expected 1 0",
                     a_ready, m_ready);
        end
        set_a(1'b0, 4'd0, 16'h0);
        set_m(1'b0, 4'd0, 16'h0);
        edge_push(1'b0, 4'd0, 16'h0);
    endtask

    task automatic test_fixed_prio;
        set_a(1'b1, 4'd10, 16'h0A0A);
        set_m(1'b1, 4'd11, 16'h0B0B);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (fp_a_ready !== 1'b1 || fp_m_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL fp_contest: cycle %0d a=%b m=%b, expected 1 0",
                         c, fp_a_ready, fp_m_ready);
            end
            if (c == 1)
                edge_push(1'b1, 4'd11, 16'h0B0B);
            else
                edge_push(1'b1, 4'd10, 16'h0A0A);
        end
        set_a(1'b0, 4'd0, 16'h0);
        #1;
        n_checks++;
        if (fp_m_ready !== 1'b1 || fp_a_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fp_m_after: a=%b m=%b, expected 0 1",
                     fp_a_ready, fp_m_ready);
        end
        edge_push(1'b1, 4'd11, 16'h0B0B);
        set_m(1'b0, 4'd0, 16'h0);
        edge_push(1'b0, 4'd0, 16'h0);
        edge_push(1'b0, 4'd0, 16'h0);
    endtask

    initial begin
        fork
            forever begin
                wr_t e;
                @(negedge clk);
                n_checks++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (wr_en !== 1'b1 || wr_reg !== e.r || wr_data !== e.d) begin
                        n_fail++;
                        $display("FAIL wr_port: en=%b reg=%0d data=%h, expected 1 %0d %h",
                                 wr_en, wr_reg, wr_data, e.r, e.d);
                    end
                end else if (wr_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wr_idle: en=%b reg=%0d, expected 0",
                             wr_en, wr_reg);
                end
            end
        join_none
        test_reset();
        test_a_only();
        test_round_robin();
        test_scoreboard();
        test_r0();
        test_async_reset();
        test_fixed_prio();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (DstReg/WriteReg/DstData) between two writeback requesters: ALU result path (requester A) and memory-load path (requester M).
- Keeps a 16-bit scoreboard of registers with an outstanding write. The issue stage uses it to detect RAW hazards and to refuse a second producer for a register (WAW).
- Sits between execute/memory stages and RegisterFile. All write-port outputs are registered.

Parameters:
- DATA_W, 16, width of write data.
- REG_W, 4, register index width; NUM_REGS = 2**REG_W.
- FIXED_PRIO, 0, 0 = round-robin between A and M; 1 = A always wins.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  ALU writeback request.
- a_reg  in  REG_W  ALU destination register.
- a_data  in  DATA_W  ALU result.
- a_ready  out  1  ALU request accepted this cycle.
- m_valid  in  1  load writeback request.
- m_reg  in  REG_W  load destination register.
- m_data  in  DATA_W  load data.
- m_ready  out  1  load request accepted this cycle.
- alloc_valid  in  1  issue stage reserves a destination register.
- alloc_reg  in  REG_W  register to reserve.
- alloc_ready  out  1  reservation accepted.
- src1_reg  in  REG_W  hazard query 1.
- src2_reg  in  REG_W  hazard query 2.
- src1_busy  out  1  src1_reg has a pending write.
- src2_busy  out  1  src2_reg has a pending write.
- wr_en  out  1  drives RegisterFile WriteReg.
- wr_reg  out  REG_W  drives DstReg.
- wr_data  out  DATA_W  drives DstData.
- busy_vec  out  NUM_REGS  scoreboard state, debug/visibility.

Behaviour:
- Reset (async, immediate):
  - wr_en=0, wr_reg=0, wr_data=0.
  - busy_vec=0.
  - Round-robin pointer = A.
  - a_ready=m_ready=0 while rst is high.
- Handshake: a transfer occurs on a rising edge where valid && ready. Requesters hold reg/data stable until accepted.
- Arbitration (combinational ready, at most one grant per cycle):
  - Only one valid: it gets ready=1.
  - Both valid, FIXED_PRIO=1: A wins.
  - Both valid, FIXED_PRIO=0: the requester not granted most recently wins. The pointer updates only on a contested grant; uncontested grants leave it unchanged.
- Write port:
  - The accepted request appears on wr_en/wr_reg/wr_data in the next cycle. Latency is 1 cycle, and wr_en is a 1-cycle pulse per accepted request.
  - With no acceptance, the next cycle has wr_en=0 and wr_reg/wr_data hold their last values.
  - Back-to-back acceptances give wr_en high on consecutive cycles. Sustained throughput is 1 write per cycle.
- R0: a request with reg=0 is accepted normally but produces wr_en=0. R0 is never marked busy.
- Scoreboard:
  - On a cycle where alloc_valid && alloc_ready: busy[alloc_reg] sets at the edge.
  - On a cycle where a request is accepted: busy[reg] clears at the edge. The bit clears at acceptance, not at the wr_en cycle. Readers must use the bypass or wait for the writeback, which the existing datapath already does.
  - Accepted write to a non-busy register: the write is performed and the scoreboard is unchanged (no error).
- alloc_ready, combinational:
  - alloc_ready = !busy[alloc_reg] || (alloc_reg == 0) || (a write to alloc_reg is being accepted this cycle).
  - Same-cycle clear and alloc on the same register: set wins, and the bit remains 1.
  - alloc_reg=0 is always ready and sets nothing.
- Hazard query: srcN_busy = busy[srcN_reg], purely combinational from current state. srcN_reg=0 always returns 0.
- Simultaneous A and M to the same register: the grant order determines the write order. The last accepted value is the final contents.
- Reset asserted mid-operation aborts any pending wr_en the same instant. Un-accepted requests are lost; requesters re-present after reset.

Test Plan:
1. Reset, then A only: a_valid=1, a_reg=3, a_data=16'h1234 → a_ready=1 same cycle; next cycle wr_en=1, wr_reg=3, wr_data=16'h1234; following cycle wr_en=0.
2. Round-robin, FIXED_PRIO=0: A (reg 2, 16'hAAAA) and M (reg 5, 16'h5555) both valid for 2 cycles → grant A then M; wr_en high two consecutive cycles with reg 2 then reg 5. Repeat the contest → grant order is A then M again.
3. Scoreboard: alloc reg 7 → busy_vec[7]=1, src1_reg=7 gives src1_busy=1. A second alloc of reg 7 → alloc_ready=0. M writes reg 7 → busy clears at the acceptance edge. Same-cycle alloc 7 with M write 7 → alloc_ready=1 and busy[7] stays 1.
4. R0: a_reg=0, a_data=16'hFFFF → a_ready=1, wr_en stays 0. alloc_reg=0 → alloc_ready=1, busy_vec stays 0, src2_reg=0 gives src2_busy=0.
5. Async reset mid-stream: assert rst between edges while wr_en=1 and busy_vec=16'h00F0 → wr_en=0 and busy_vec=0 immediately, before the next edge. After deassert, next contested grant goes to A.
6. FIXED_PRIO=1: A and M both valid for 3 cycles → A granted all 3 and m_ready=0 throughout. M is granted on the first cycle A deasserts.
